// File: rtl/bus_fabric.sv
// Single-master address decoder and response sequencer for one RAM region plus N_SLV peripheral slots.
// Optional access timeout enabled by defining BUS_TIMEOUT_EN.
module bus_fabric #(
    parameter int          N_SLV       = 7,
    parameter logic [31:0] RAM_BASE    = 32'h1000,
    parameter int          RAM_WORDS   = 256,
    parameter logic [31:0] PERIPH_BASE = 32'h2000,
    parameter int          SLOT_STRIDE = 16,
    parameter int          TIMEOUT     = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [31:0]              addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o,
    output logic                     ready_o,
    output logic                     err_o,
    output logic [N_SLV:0]           sel_o,
    output logic                     we_o,
    output logic [15:0]              tgt_addr_o,
    output logic [31:0]              wdata_o,
    input  logic [32*(N_SLV+1)-1:0]  rdata_i,
    input  logic [N_SLV:0]           ack_i,
    output logic [31:0]              fault_addr_o
);

    localparam int NT = N_SLV + 1;
    // Region limits are held in 33 bits so an upper bound near 4 GiB cannot wrap to a small value.
    localparam logic [32:0] RAM_LO = {1'b0, RAM_BASE};
    localparam logic [32:0] RAM_HI = RAM_LO + (33'(RAM_WORDS) * 33'd4);
    localparam logic [32:0] PER_LO = {1'b0, PERIPH_BASE};
    localparam logic [32:0] STRIDE = 33'(SLOT_STRIDE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [NT-1:0]   sel_r;
    logic            we_r;
    logic [15:0]     tgt_r;
    logic [31:0]     wdata_r;
    logic [31:0]     rdata_r;
    logic            ready_r;
    logic            err_r;
    logic [31:0]     fault_r;

    logic [NT-1:0]   dec_sel_s;
    logic [15:0]     dec_off_s;
    logic [32:0]     addr33_s;
    logic [31:0]     sel_rdata_s;
    logic            ack_hit_s;
    logic            tmo_s;
    logic [31:0]     tmo_addr_s;

    // Address decode of the live master address into a one-hot target and word offset.
    always_comb begin
        dec_sel_s = '0;
        dec_off_s = 16'h0000;
        addr33_s  = {1'b0, addr_i};
        if (addr_i[1:0] != 2'b00) begin
            dec_sel_s = '0;
        end else if ((addr33_s >= RAM_LO) && (addr33_s < RAM_HI)) begin
            dec_sel_s[0] = 1'b1;
            dec_off_s    = 16'((addr33_s - RAM_LO) >> 2);
        end else begin
            for (int k = 0; k < N_SLV; k++) begin
                if ((addr33_s >= (PER_LO + STRIDE * 33'(k))) &&
                    (addr33_s <  (PER_LO + STRIDE * 33'(k + 1)))) begin
                    dec_sel_s[k+1] = 1'b1;
                    dec_off_s      = 16'((addr33_s - PER_LO - STRIDE * 33'(k)) >> 2);
                end else begin
                    dec_sel_s[k+1] = 1'b0;
                end
            end
        end
    end

    // Read-data mux and acknowledge filter, both gated by the registered select.
    always_comb begin
        sel_rdata_s = 32'h0000_0000;
        for (int t = 0; t < NT; t++) begin
            sel_rdata_s = sel_rdata_s | (rdata_i[32*t +: 32] & {32{sel_r[t]}});
        end
        ack_hit_s = (state_r == ACCESS) && ((ack_i & sel_r) != '0);
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      addr_r;

    // Counts ACCESS cycles; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_r <= '0;
        end else if (state_r == ACCESS) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= '0;
        end
    end

    // Keeps the request address so a timeout can report it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_r <= 32'h0000_0000;
        end else if ((state_r == IDLE) && req_i) begin
            addr_r <= addr_i;
        end else begin
            addr_r <= addr_r;
        end
    end

    assign tmo_s      = (state_r == ACCESS) && (cnt_r == CNT_W'(TIMEOUT - 1));
    assign tmo_addr_s = addr_r;
`else
    assign tmo_s      = 1'b0;
    assign tmo_addr_s = 32'h0000_0000;
`endif

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_i) begin
                    if (dec_sel_s != '0) begin
                        state_nxt_s = ACCESS;
                    end else begin
                        state_nxt_s = RESP;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (ack_hit_s || tmo_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Target-side and master-side output registers; ack takes priority over a coincident timeout.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sel_r   <= '0;
            we_r    <= 1'b0;
            tgt_r   <= 16'h0000;
            wdata_r <= 32'h0000_0000;
            rdata_r <= 32'h0000_0000;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            fault_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b0;
                    err_r   <= 1'b0;
                    rdata_r <= 32'h0000_0000;
                    if (req_i && (dec_sel_s != '0)) begin
                        sel_r   <= dec_sel_s;
                        we_r    <= we_i;
                        tgt_r   <= dec_off_s;
                        wdata_r <= wdata_i;
                    end else if (req_i) begin
                        ready_r <= 1'b1;
                        err_r   <= 1'b1;
                        fault_r <= addr_i;
                    end else begin
                        sel_r <= '0;
                    end
                end
                ACCESS: begin
                    if (ack_hit_s) begin
                        sel_r   <= '0;
                        we_r    <= 1'b0;
                        ready_r <= 1'b1;
                        err_r   <= 1'b0;
                        rdata_r <= we_r ? 32'h0000_0000 : sel_rdata_s;
                    end else if (tmo_s) begin
                        sel_r   <= '0;
                        we_r    <= 1'b0;
                        ready_r <= 1'b1;
                        err_r   <= 1'b1;
                        rdata_r <= 32'h0000_0000;
                        fault_r <= tmo_addr_s;
                    end else begin
                        sel_r <= sel_r;
                    end
                end
                RESP: begin
                    sel_r   <= '0;
                    we_r    <= 1'b0;
                    ready_r <= 1'b0;
                    err_r   <= 1'b0;
                    rdata_r <= 32'h0000_0000;
                end
                default: begin
                    sel_r   <= '0;
                    we_r    <= 1'b0;
                    ready_r <= 1'b0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign sel_o        = sel_r;
    assign we_o         = we_r;
    assign tgt_addr_o   = tgt_r;
    assign wdata_o      = wdata_r;
    assign rdata_o      = rdata_r;
    assign ready_o      = ready_r;
    assign err_o        = err_r;
    assign fault_addr_o = fault_r;

endmodule

// File: tb/tb_bus_fabric.sv
// Scoreboard bench for bus_fabric: expected responses are queued at request time and
// checked by a monitor whenever ready_o pulses; timing and select checks are inline per test.
module tb_bus_fabric;

    localparam int NT = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [31:0]       addr = 32'h0;
    logic [31:0]       wdata = 32'h0;
    logic [31:0]       rdata;
    logic              ready;
    logic              err;
    logic [NT-1:0]     sel;
    logic              we_out;
    logic [15:0]       tgt_addr;
    logic [31:0]       wdata_out;
    logic [32*NT-1:0]  rdata_in = '0;
    logic [NT-1:0]     ack = '0;
    logic [31:0]       fault_addr;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] fault;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_fault = 32'h0;

    bus_fabric dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata), .ready_o(ready), .err_o(err), .sel_o(sel),
        .we_o(we_out), .tgt_addr_o(tgt_addr), .wdata_o(wdata_out), .rdata_i(rdata_in),
        .ack_i(ack), .fault_addr_o(fault_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int t);
        return 32'hC0DE_0000 + 32'(t) * 32'h0000_0111;
    endfunction

    // Queue the expected response, then present a one-cycle request (called at a negedge in IDLE).
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic exp_err, input int t);
        exp_t e;
        if (exp_err) last_fault = a;
        e.err   = exp_err;
        e.rdata = (exp_err || w) ? 32'h0 : pat(t);
        e.fault = last_fault;
        sb.push_back(e);
        req = 1'b1; addr = a; we = w; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic pulse_ack(input int t);
        ack = '0;
        ack[t] = 1'b1;
        @(posedge clk); #1;
        ack = '0;
    endtask

    // Bounded wait for ready_o; lat = negedges waited, -1 if it never came. Leaves the FSM in IDLE.
    task automatic wait_ready(input int max_cyc, output int lat);
        lat = 0;
        while (ready !== 1'b1 && lat < max_cyc) begin
            @(negedge clk);
            lat++;
        end
        if (ready !== 1'b1) lat = -1;
        @(negedge clk);
    endtask

    // Response monitor: pops the scoreboard on every ready pulse.
    initial begin : monitor
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ready === 1'b1) begin
                n_cmp++;
                if (prev === 1'b1) begin
                    n_bad++;
                    $display("FAIL ready_width: ready_o high 2+ cycles, required 1");
                end else if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_resp: ready_o=1 with no request outstanding");
                end else begin
                    e = sb.pop_front();
                    if ({rdata, err, fault_addr} !== {e.rdata, e.err, e.fault}) begin
                        n_bad++;
                        $display("FAIL resp: got rdata=%h err=%b fault=%h, required rdata=%h err=%b fault=%h",
                                 rdata, err, fault_addr, e.rdata, e.err, e.fault);
                    end
                end
            end
            prev = ready;
        end
    end

    task automatic test_reset;
        req = 1'b1; addr = 32'h1000;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ready, err, rdata, sel, we_out, tgt_addr, wdata_out, fault_addr} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ready=%b err=%b rdata=%h sel=%b fault=%h, required all 0",
                     ready, err, rdata, sel, fault_addr);
        end
        req = 1'b0; rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ram_read;
        logic [31:0] a[2]  = '{32'h13FC, 32'h1000};
        logic [15:0] to[2] = '{16'h00FF, 16'h0000};
        int lat;
        for (int i = 0; i < 2; i++) begin
            issue(a[i], 1'b0, 32'h0, 1'b0, 0);
            @(negedge clk);
            n_cmp++;
            if (sel !== 8'h01 || tgt_addr !== to[i] || we_out !== 1'b0) begin
                n_bad++;
                $display("FAIL ram_sel: got sel=%b tgt=%h we=%b, required sel=00000001 tgt=%h we=0",
                         sel, tgt_addr, we_out, to[i]);
            end
            pulse_ack(0);
            @(negedge clk);
            wait_ready(4, lat);
            n_cmp++;
            if (lat !== 0) begin
                n_bad++;
                $display("FAIL ram_latency: got %0d extra cycles, required 0", lat);
            end
        end
    endtask

    task automatic test_slot_write;
        logic [31:0] a[3]  = '{32'h2010, 32'h206C, 32'h1004};
        logic [31:0] d[3]  = '{32'h0000_0004, 32'hDEAD_BEEF, 32'h1234_5678};
        int          t[3]  = '{2, 7, 0};
        logic [15:0] to[3] = '{16'h0000, 16'h0003, 16'h0001};
        int lat;
        logic [NT-1:0] oh;
        for (int i = 0; i < 3; i++) begin
            oh = '0;
            oh[t[i]] = 1'b1;
            issue(a[i], 1'b1, d[i], 1'b0, t[i]);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                n_cmp++;
                if (sel !== oh || we_out !== 1'b1 || tgt_addr !== to[i] || wdata_out !== d[i]) begin
                    n_bad++;
                    $display("FAIL write_hold%0d: got sel=%b we=%b tgt=%h wdata=%h, required sel=%b we=1 tgt=%h wdata=%h",
                             c, sel, we_out, tgt_addr, wdata_out, oh, to[i], d[i]);
                end
            end
            pulse_ack(t[i]);
            @(negedge clk);
            wait_ready(4, lat);
            n_cmp++;
            if (lat !== 0) begin
                n_bad++;
                $display("FAIL write_latency: got %0d extra cycles, required 0", lat);
            end
        end
    endtask

    task automatic test_errors;
        logic [31:0] a[6] = '{32'h1400, 32'h2070, 32'h2002, 32'h0FFC, 32'hFFFF_FFFC, 32'h1001};
        int lat;
        for (int i = 0; i < 6; i++) begin
            issue(a[i], 1'b0, 32'h0, 1'b1, 0);
            @(negedge clk);
            n_cmp++;
            if (sel !== 8'h00 || ready !== 1'b1 || fault_addr !== a[i]) begin
                n_bad++;
                $display("FAIL err_decode: got sel=%b ready=%b fault=%h, required sel=0 ready=1 fault=%h",
                         sel, ready, fault_addr, a[i]);
            end
            wait_ready(4, lat);
        end
    endtask

    task automatic test_ignore_ack;
        int lat;
        issue(32'h2000, 1'b0, 32'h0, 1'b0, 1);
        @(negedge clk);
        pulse_ack(3);
        @(negedge clk);
        n_cmp++;
        if (sel !== 8'h02 || ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_ack: got sel=%b ready=%b, required sel=00000010 ready=0", sel, ready);
        end
        pulse_ack(1);
        @(negedge clk);
        wait_ready(4, lat);
        n_cmp++;
        if (lat !== 0) begin
            n_bad++;
            $display("FAIL ignore_ack_resp: got %0d extra cycles, required 0", lat);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic r[4];
        last_fault = 32'h2002;
        e = '{rdata: 32'h0, err: 1'b1, fault: 32'h2002}; sb.push_back(e);
        last_fault = 32'h1400;
        e = '{rdata: 32'h0, err: 1'b1, fault: 32'h1400}; sb.push_back(e);
        e = '{rdata: pat(0), err: 1'b0, fault: 32'h1400}; sb.push_back(e);
        req = 1'b1; addr = 32'h2002; we = 1'b0;
        @(posedge clk); #1;
        addr = 32'h1400;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            r[i] = ready;
        end
        n_cmp++;
        if ({r[0], r[1], r[2], r[3]} !== 4'b1010) begin
            n_bad++;
            $display("FAIL b2b_ready: got %b%b%b%b, required 1010", r[0], r[1], r[2], r[3]);
        end
        addr = 32'h1000;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (sel !== 8'h01) begin
            n_bad++;
            $display("FAIL b2b_sel: got sel=%b, required 00000001", sel);
        end
        pulse_ack(0);
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_third: got ready=%b, required 1", ready);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access;
        int lat;
        logic seen;
        seen = 1'b0;
        req = 1'b1; addr = 32'h2020; we = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | ready;
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (sel !== 8'h00 || fault_addr !== 32'h0 || seen !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_abort: got sel=%b fault=%h early_ready=%b, required sel=0 fault=0 early_ready=0",
                     sel, fault_addr, seen);
        end
        last_fault = 32'h0;
        pulse_ack(3);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0 || sel !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_no_ready: got ready=%b sel=%b, required 0 and 0", ready, sel);
        end
        issue(32'h2020, 1'b0, 32'h0, 1'b0, 3);
        @(negedge clk);
        n_cmp++;
        if (sel !== 8'h08) begin
            n_bad++;
            $display("FAIL reset_recover_sel: got sel=%b, required 00001000", sel);
        end
        pulse_ack(3);
        @(negedge clk);
        wait_ready(4, lat);
        n_cmp++;
        if (lat !== 0) begin
            n_bad++;
            $display("FAIL reset_recover: got %0d extra cycles, required 0", lat);
        end
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout;
        int lat;
        issue(32'h2000, 1'b0, 32'h0, 1'b1, 1);
        @(negedge clk);
        wait_ready(30, lat);
        n_cmp++;
        if (lat !== 15) begin
            n_bad++;
            $display("FAIL timeout_latency: got %0d cycles after sel, required 15", lat);
        end
        issue(32'h2000, 1'b0, 32'h0, 1'b0, 1);
        repeat (14) @(negedge clk);
        pulse_ack(1);
        @(negedge clk);
        wait_ready(4, lat);
        n_cmp++;
        if (lat !== 0) begin
            n_bad++;
            $display("FAIL timeout_ack_wins: got %0d extra cycles, required 0", lat);
        end
    endtask
`else
    task automatic test_no_timeout;
        int lat;
        logic seen;
        seen = 1'b0;
        issue(32'h2030, 1'b0, 32'h0, 1'b0, 4);
        repeat (40) begin
            @(negedge clk);
            seen = seen | ready;
        end
        n_cmp++;
        if (seen !== 1'b0 || sel !== 8'h10) begin
            n_bad++;
            $display("FAIL no_timeout: got early_ready=%b sel=%b, required 0 and 00010000", seen, sel);
        end
        pulse_ack(4);
        @(negedge clk);
        wait_ready(4, lat);
        n_cmp++;
        if (lat !== 0) begin
            n_bad++;
            $display("FAIL no_timeout_resp: got %0d extra cycles, required 0", lat);
        end
    endtask
`endif

    initial begin
        for (int t = 0; t < NT; t++) rdata_in[32*t +: 32] = pat(t);
        test_reset;
        test_ram_read;
        test_slot_write;
        test_errors;
        test_ignore_ack;
        test_back_to_back;
        test_reset_mid_access;
`ifdef BUS_TIMEOUT_EN
        test_timeout;
`else
        test_no_timeout;
`endif
        repeat (2) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: got %0d responses missing, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
